multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main controller of the multicycle RV32 core. Decodes the latched instruction fields.
//  Sequences the shared datapath (one ALU, one memory port, regfile) over several cycles.
//  Drives alucontrol (3'b000 add, 001 sub, 010 and, 011 or), mux selects and write strobes.
//  Handshakes with memory through mem_req/mem_ready.
// PARAMETERS
//  ALUCTRL_W   3   width of alucontrol; must match the ALU select field
// PORTS
//  clk          in   1          core clock, all state updates on rising edge
//  reset_n      in   1          synchronous active-low reset
//  op           in   7          instr[6:0] from instruction register
//  funct3       in   3          instr[14:12]
//  funct7b5     in   1          instr[30]
//  zero         in   1          ALU zero flag (result == 0)
//  mem_ready    in   1          memory accepted/returned data this cycle
//  mem_req      out  1          memory access request, held until mem_ready
//  mem_write    out  1          store strobe, valid with mem_req
//  adr_src      out  1          0: PC, 1: ALU-out register drives memory address
//  ir_write     out  1          latch instruction register
//  pc_write     out  1          update PC from result bus
//  reg_write    out  1          regfile write enable
//  alu_src_a    out  2          00 PC, 01 oldPC, 10 rs1
//  alu_src_b    out  2          00 rs2, 01 imm, 10 const 4
//  result_src   out  2          00 ALU-out reg, 01 mem data, 10 ALU result direct
//  imm_src      out  2          00 I, 01 S, 10 B, 11 J (decoded from op, combinational)
//  alucontrol   out  ALUCTRL_W  ALU operation select
//  illegal      out  1          illegal-instruction flag (ILLEGAL_TRAP_EN only, else 0)
// BEHAVIOUR
//  - Outputs are decoded from the state register.
//  - Mealy terms: ir_write/pc_write in FETCH = mem_ready; pc_write in BRANCH.
//  - reset_n=0 at edge: state<=FETCH. While reset_n=0, all strobes are forced to 0.
//    Forced strobes: mem_req, mem_write, ir_write, pc_write, reg_write, illegal.
//  - While reset_n=0, all selects and alucontrol are 0.
//  - Reset mid-access drops mem_req the same cycle; no write is completed.
//  - Unlisted selects are 0 in each state. alucontrol defaults to add.
//  - FETCH:    mem_req, adr_src=0, a=00, b=10, add, result_src=10.
//              Stays in FETCH until mem_ready, then goes to DECODE.
//  - DECODE:   a=01, b=01, add (branch target into ALU-out).
//              Next state by op:
//              0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I.
//              1101111 -> JAL; 1100011 -> BRANCH; other -> illegal handling.
//  - MEMADR:   a=10, b=01, add. Next MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
//  - MEMREAD:  mem_req, adr_src=1. Waits for mem_ready, then MEMWB.
//  - MEMWB:    result_src=01, reg_write. Next FETCH.
//  - MEMWRITE: mem_req, mem_write, adr_src=1. Waits for mem_ready, then FETCH.
//  - EXEC_R:   a=10, b=00, then ALUWB.
//  - EXEC_I:   a=10, b=01, then ALUWB.
//  - EXEC_R/EXEC_I alucontrol by funct3:
//      000 -> add, or sub when op[5]&funct7b5; 111 -> and; 110 -> or.
//      Other funct3 values are illegal.
//  - ALUWB:    result_src=00, reg_write. Next FETCH.
//  - JAL:      a=01, b=10, add, result_src=00, pc_write=1. Next ALUWB (rd = PC+4).
//  - BRANCH:   a=10, b=00, sub, result_src=00. Next FETCH.
//              pc_write = zero for funct3=000, ~zero for 001; any other funct3 is illegal.
//  - Latency (with mem_ready=1):
//      R/I 4 cycles; sw 4; lw 5; jal 4; branch 3.
//      Each mem_ready=0 cycle adds 1 cycle.
//  - mem_req never deasserts without mem_ready, except under reset.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    Any illegal op/funct3 enters TRAP; illegal=1 there; no strobes.
//    The FSM stays in TRAP until reset_n=0.
//  ILLEGAL_TRAP_EN undefined:
//    Illegal instructions return to FETCH with no reg/mem/pc side effect (NOP).
//    illegal is tied to 0.
// TESTING
//  1. reset_n=0 for 2 cycles, mem_ready=1 -> all strobes 0; first cycle after release is FETCH.
//     That first FETCH cycle shows mem_req=1, pc_write=1, ir_write=1.
//  2. op=0110011, funct3=000, funct7b5=1 -> EXEC_R alucontrol=001; reg_write in cycle 4.
//  3. lw (op=0000011) with mem_ready low 2 cycles in MEMREAD -> mem_req held 3 cycles.
//     reg_write with result_src=01 on the following cycle; lw total 7 cycles.
//  4. beq: zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0.
//     bne (funct3=001) inverts this.
//  5. op=1111111 with ILLEGAL_TRAP_EN defined -> illegal=1 and TRAP held; cleared by reset.
//     op=1111111 without the macro -> FETCH next cycle, no strobes.
//  6. reset_n=0 during MEMWRITE with mem_ready=0 -> mem_req=0 and mem_write=0 that cycle.
//     After release, state is FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Memory-port handshake between the multicycle controller and the shared memory.
// The controller is the master: it raises mem_req and the memory answers with mem_ready.
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main controller of the multicycle RV32 core: sequences fetch/decode/execute on the shared datapath.
// Build option ILLEGAL_TRAP_EN: illegal instructions park in TRAP with illegal=1 instead of acting as NOP.
module multicycle_control_fsm #(
    parameter int ALUCTRL_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    multicycle_control_fsm_if.master mem,
    input  logic [6:0]               op,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     zero,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     reg_write,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               result_src,
    output logic [1:0]               imm_src,
    output logic [ALUCTRL_W-1:0]     alucontrol,
    output logic                     illegal
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXEC_R, EXEC_I, ALUWB, JAL, BRANCH, TRAP
    } state_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_DEST = TRAP;
`else
    localparam state_t ILL_DEST = FETCH;
`endif

    state_t state;
    state_t state_nxt;

    function automatic logic alu_funct3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [ALUCTRL_W-1:0] alu_op(input logic [2:0] f3, input logic sub_sel);
        case (f3)
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mem.mem_req   = 1'b0;
        mem.mem_write = 1'b0;
        mem.adr_src   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alucontrol    = ALU_ADD;
        illegal       = 1'b0;

        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase

        case (state)
            FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                ir_write    = mem.mem_ready;
                pc_write    = mem.mem_ready;
                if (mem.mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                // ALU-out captures the branch target while the opcode is resolved
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_R:              state_nxt = alu_funct3_ok(funct3) ? EXEC_R : ILL_DEST;
                    OP_I:              state_nxt = alu_funct3_ok(funct3) ? EXEC_I : ILL_DEST;
                    OP_JAL:            state_nxt = JAL;
                    OP_BRANCH:         state_nxt = (funct3[2:1] == 2'b00) ? BRANCH : ILL_DEST;
                    default:           state_nxt = ILL_DEST;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem.mem_req = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ready) state_nxt = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nxt  = FETCH;
            end
            MEMWRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_write = 1'b1;
                mem.adr_src   = 1'b1;
                if (mem.mem_ready) state_nxt = FETCH;
            end
            EXEC_R: begin
                alu_src_a  = 2'b10;
                alucontrol = alu_op(funct3, op[5] & funct7b5);
                state_nxt  = ALUWB;
            end
            EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alucontrol = alu_op(funct3, op[5] & funct7b5);
                state_nxt  = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_nxt = FETCH;
            end
            JAL: begin
                // PC takes the target held in ALU-out while the ALU forms oldPC+4 for rd
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_nxt = ALUWB;
            end
            BRANCH: begin
                alu_src_a  = 2'b10;
                alucontrol = ALU_SUB;
                pc_write   = funct3[0] ? ~zero : zero;
                state_nxt  = FETCH;
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
                state_nxt = TRAP;
            end
            default: state_nxt = FETCH;
        endcase

        // Reset silences every strobe and select in the same cycle, even mid-access
        if (!reset_n) begin
            mem.mem_req   = 1'b0;
            mem.mem_write = 1'b0;
            mem.adr_src   = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            result_src    = 2'b00;
            imm_src       = 2'b00;
            alucontrol    = ALU_ADD;
            illegal       = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected cycle traces built from the
// instruction class, stall counts and branch flag, replayed against the DUT cycle by cycle.
module tb_multicycle_control_fsm;
    localparam int ALUCTRL_W = 3;

`ifdef ILLEGAL_TRAP_EN
    localparam int TRAP_CYC = 3;
`else
    localparam int TRAP_CYC = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [6:0]           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 zero;
    logic                 ir_write, pc_write, reg_write, illegal;
    logic [1:0]           alu_src_a, alu_src_b, result_src, imm_src;
    logic [ALUCTRL_W-1:0] alucontrol;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.ALUCTRL_W(ALUCTRL_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem        (bus),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    // One cycle of stimulus plus the outputs that cycle must show
    typedef struct packed {
        logic       rst_n, rdy, z;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, ill;
        logic [1:0] a, b, rs, imm;
        logic [2:0] alu;
    } cyc_t;

    cyc_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic cyc_t quiet(input logic [6:0] o, input logic [2:0] f, input logic f7);
        cyc_t c;
        c       = '0;
        c.rst_n = 1'b1;
        c.rdy   = 1'($urandom);
        c.z     = 1'($urandom);
        c.op    = o;
        c.f3    = f;
        c.f7    = f7;
        c.imm   = imm_of(o);
        return c;
    endfunction

    function automatic void push_reset(input logic rdy);
        cyc_t c;
        c       = '0;
        c.rdy   = rdy;
        c.z     = 1'($urandom);
        c.op    = 7'($urandom);
        c.f3    = 3'($urandom);
        exp_q.push_back(c);
    endfunction

    function automatic void illegal_tail(input logic [6:0] o, input logic [2:0] f, input logic f7);
        cyc_t c;
        for (int i = 0; i < TRAP_CYC; i++) begin
            c     = quiet(o, f, f7);
            c.ill = 1'b1;
            exp_q.push_back(c);
        end
        if (TRAP_CYC > 0) push_reset(1'($urandom));
    endfunction

    // Expected trace of one instruction; returns the number of cycles appended
    function automatic int build(input logic [6:0] o, input logic [2:0] f, input logic f7,
                                 input int fstall, input int mstall, input logic z);
        cyc_t c;
        int   n0     = exp_q.size();
        logic alu_ok = (f == 3'b000) || (f == 3'b110) || (f == 3'b111);
        for (int i = 0; i <= fstall; i++) begin
            c          = quiet(o, f, f7);
            c.rdy      = (i == fstall);
            c.mem_req  = 1'b1;
            c.b        = 2'b10;
            c.rs       = 2'b10;
            c.ir_write = c.rdy;
            c.pc_write = c.rdy;
            exp_q.push_back(c);
        end
        c   = quiet(o, f, f7);
        c.a = 2'b01;
        c.b = 2'b01;
        exp_q.push_back(c);
        case (o)
            7'b0110011, 7'b0010011: begin
                if (alu_ok) begin
                    c     = quiet(o, f, f7);
                    c.a   = 2'b10;
                    c.b   = (o == 7'b0010011) ? 2'b01 : 2'b00;
                    if (f == 3'b111)      c.alu = 3'b010;
                    else if (f == 3'b110) c.alu = 3'b011;
                    else if (o == 7'b0110011 && f7) c.alu = 3'b001;
                    else                  c.alu = 3'b000;
                    exp_q.push_back(c);
                    c           = quiet(o, f, f7);
                    c.reg_write = 1'b1;
                    exp_q.push_back(c);
                end else begin
                    illegal_tail(o, f, f7);
                end
            end
            7'b0000011, 7'b0100011: begin
                c   = quiet(o, f, f7);
                c.a = 2'b10;
                c.b = 2'b01;
                exp_q.push_back(c);
                for (int i = 0; i <= mstall; i++) begin
                    c           = quiet(o, f, f7);
                    c.rdy       = (i == mstall);
                    c.mem_req   = 1'b1;
                    c.adr_src   = 1'b1;
                    c.mem_write = (o == 7'b0100011);
                    exp_q.push_back(c);
                end
                if (o == 7'b0000011) begin
                    c           = quiet(o, f, f7);
                    c.rs        = 2'b01;
                    c.reg_write = 1'b1;
                    exp_q.push_back(c);
                end
            end
            7'b1101111: begin
                c          = quiet(o, f, f7);
                c.a        = 2'b01;
                c.b        = 2'b10;
                c.pc_write = 1'b1;
                exp_q.push_back(c);
                c           = quiet(o, f, f7);
                c.reg_write = 1'b1;
                exp_q.push_back(c);
            end
            7'b1100011: begin
                if (f == 3'b000 || f == 3'b001) begin
                    c          = quiet(o, f, f7);
                    c.z        = z;
                    c.a        = 2'b10;
                    c.alu      = 3'b001;
                    c.pc_write = (f == 3'b000) ? z : !z;
                    exp_q.push_back(c);
                end else begin
                    illegal_tail(o, f, f7);
                end
            end
            default: illegal_tail(o, f, f7);
        endcase
        return exp_q.size() - n0;
    endfunction

    function automatic logic [2:0] pick_alu_f3();
        case ($urandom_range(0, 3))
            0:       return 3'b000;
            1:       return 3'b110;
            2:       return 3'b111;
            default: return 3'($urandom);
        endcase
    endfunction

    cyc_t e;
    int   n;

    initial begin
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        zero          = 1'b0;
        op            = 7'b0;
        funct3        = 3'b0;
        funct7b5      = 1'b0;

        // Hand-computed expectations that pin the trace model
        n = build(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0);
        chk("len_r", n, 4);
        chk("r_sub_alu", exp_q[2].alu, 3'b001);
        chk("r_wb_cycle4", exp_q[3].reg_write, 1);
        chk("fetch_pc_write", exp_q[0].pc_write, 1);
        exp_q.delete();
        chk("len_sw", build(7'b0100011, 3'b010, 1'b0, 0, 0, 1'b0), 4);
        exp_q.delete();
        chk("len_lw", build(7'b0000011, 3'b010, 1'b0, 0, 0, 1'b0), 5);
        exp_q.delete();
        chk("len_lw_stall2", build(7'b0000011, 3'b010, 1'b0, 0, 2, 1'b0), 7);
        chk("lw_wb_src", exp_q[6].rs, 2'b01);
        chk("lw_req_held", exp_q[5].mem_req, 1);
        exp_q.delete();
        chk("len_jal", build(7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0), 4);
        exp_q.delete();
        chk("len_beq", build(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1), 3);
        chk("beq_taken", exp_q[2].pc_write, 1);
        exp_q.delete();
        void'(build(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1));
        chk("bne_not_taken", exp_q[2].pc_write, 0);
        exp_q.delete();

        // Directed scenarios, then randomized instruction stream
        push_reset(1'b1);
        push_reset(1'b1);
        void'(build(7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0));
        void'(build(7'b0000011, 3'b010, 1'b0, 0, 2, 1'b0));
        void'(build(7'b1100011, 3'b000, 1'b0, 1, 0, 1'b1));
        void'(build(7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0));
        void'(build(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b1));
        void'(build(7'b1100011, 3'b001, 1'b0, 0, 0, 1'b0));
        void'(build(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0));
        void'(build(7'b0100011, 3'b010, 1'b0, 0, 1, 1'b0));
        void'(exp_q.pop_back());
        push_reset(1'b0);
        for (int k = 0; k < 150; k++) begin
            int fs = $urandom_range(0, 2);
            int ms = $urandom_range(0, 2);
            logic f7 = 1'($urandom);
            logic z  = 1'($urandom);
            case ($urandom_range(0, 7))
                0: void'(build(7'b0110011, pick_alu_f3(), f7, fs, ms, z));
                1: void'(build(7'b0010011, pick_alu_f3(), f7, fs, ms, z));
                2: void'(build(7'b0000011, 3'($urandom), f7, fs, ms, z));
                3: void'(build(7'b0100011, 3'($urandom), f7, fs, ms, z));
                4: void'(build(7'b1101111, 3'($urandom), f7, fs, ms, z));
                5: void'(build(7'b1100011, 3'($urandom_range(0, 1)), f7, fs, ms, z));
                6: void'(build(7'b1100011, 3'($urandom), f7, fs, ms, z));
                default: void'(build(7'($urandom), 3'($urandom), f7, fs, ms, z));
            endcase
            if ($urandom_range(0, 19) == 0) push_reset(1'($urandom));
        end

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            reset_n       = e.rst_n;
            bus.mem_ready = e.rdy;
            zero          = e.z;
            op            = e.op;
            funct3        = e.f3;
            funct7b5      = e.f7;
            @(negedge clk);
            chk("mem_req", bus.mem_req, e.mem_req);
            chk("mem_write", bus.mem_write, e.mem_write);
            chk("adr_src", bus.adr_src, e.adr_src);
            chk("ir_write", ir_write, e.ir_write);
            chk("pc_write", pc_write, e.pc_write);
            chk("reg_write", reg_write, e.reg_write);
            chk("illegal", illegal, e.ill);
            chk("alu_src_a", alu_src_a, e.a);
            chk("alu_src_b", alu_src_b, e.b);
            chk("result_src", result_src, e.rs);
            chk("imm_src", imm_src, e.imm);
            chk("alucontrol", alucontrol, e.alu);
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
